// File: rtl/expr_paren.sv
// expr_paren: streaming syntax checker for parenthesised infix expressions with
// depth tracking and a saturating character counter. Macro EXPR_MULTIDIGIT_EN enables multi-digit operands.
module expr_paren #(
  parameter int MAX_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [3:0]       depth,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S_OPND = 2'd0,
    S_DIG  = 2'd1,
    S_CLS  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0]       MAX_D   = 4'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       depth_q, depth_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             err_q, err_d;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic logic is_oper(input logic [7:0] c);
    return (c == 8'd43) || (c == 8'd45) || (c == 8'd42) || (c == 8'd47);
  endfunction

  // Next-state, depth, counter and Moore output computation
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        S_OPND: begin
          if (is_digit(in)) begin
            state_d = S_DIG;
          end else if ((in == 8'd40) && (depth_q != MAX_D)) begin
            state_d = S_OPND;
            depth_d = depth_q + 4'd1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_DIG, S_CLS: begin
          if (is_oper(in)) begin
            state_d = S_OPND;
          end else if ((in == 8'd41) && (depth_q != 4'd0)) begin
            state_d = S_CLS;
            depth_d = depth_q - 4'd1;
          end else if (is_digit(in) && (state_q == S_DIG)) begin
`ifdef EXPR_MULTIDIGIT_EN
            state_d = S_DIG;
`else
            state_d = S_ERR;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_ERR;
      endcase
    end else begin
      state_d = state_q;
    end
    out_d = ((state_d == S_DIG) || (state_d == S_CLS)) && (depth_d == 4'd0);
    err_d = (state_d == S_ERR);
  end

  // State and registered outputs; clr wipes all history immediately
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_OPND;
      depth_q <= 4'd0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out   = out_q;
  assign err   = err_q;
  assign depth = depth_q;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_expr_paren.sv
// Scoreboard bench for expr_paren: a grammar-level reference model of the stream
// history predicts each cycle's outputs, and a monitor process compares them.
module tb_expr_paren;
  localparam int MAX_DEPTH = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef EXPR_MULTIDIGIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic [7:0]       in_s;
  logic             out;
  logic             err;
  logic [3:0]       depth;
  logic [CNT_W-1:0] cnt;

  typedef struct {
    logic             o;
    logic             e;
    logic [3:0]       d;
    logic [CNT_W-1:0] c;
  } exp_t;

  exp_t        exp_q[$];
  byte unsigned hist[$];
  int          total  = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  expr_paren #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_s),
    .out(out), .err(err), .depth(depth), .cnt(cnt)
  );

  function automatic bit c_dig(input byte unsigned c);
    return (c >= 8'd48) && (c <= 8'd57);
  endfunction

  function automatic bit c_op(input byte unsigned c);
    return (c == 8'd43) || (c == 8'd45) || (c == 8'd42) || (c == 8'd47);
  endfunction

  // Re-scan the whole accepted history: each char is legal only if it may follow its predecessor.
  function automatic exp_t model();
    exp_t         r;
    int           bal;
    bit           bad;
    bit           have;
    bit           start;
    bit           after_val;
    bit           ok;
    byte unsigned prev;
    byte unsigned c;
    bal = 0; bad = 1'b0; have = 1'b0; prev = 8'd0;
    foreach (hist[i]) begin
      if (!bad) begin
        c         = hist[i];
        start     = !have || (prev == 8'd40) || c_op(prev);
        after_val = have && (c_dig(prev) || (prev == 8'd41));
        if (c_dig(c))           ok = start || (MULTI && have && c_dig(prev));
        else if (c_op(c))       ok = after_val;
        else if (c == 8'd40)    ok = start && (bal < MAX_DEPTH);
        else if (c == 8'd41)    ok = after_val && (bal > 0);
        else                    ok = 1'b0;
        if (ok) begin
          if (c == 8'd40) bal++;
          if (c == 8'd41) bal--;
          prev = c;
          have = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
    end
    r.o = !bad && have && (c_dig(prev) || (prev == 8'd41)) && (bal == 0);
    r.e = bad;
    r.d = 4'(bal);
    r.c = (total > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(total);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit v, input byte unsigned c);
    @(negedge clk);
    in_valid = v;
    in_s     = c;
    if (v) begin
      total++;
      hist.push_back(c);
    end
    exp_q.push_back(model());
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  // Asynchronous reset pulse placed between clock edges, checked before release.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #1 clr = 1'b0;
    #2;
    chk("rst_out", out, 0);
    chk("rst_err", err, 0);
    chk("rst_depth", depth, 0);
    chk("rst_cnt", cnt, 0);
    #1 clr = 1'b1;
    hist.delete();
    total = 0;
  endtask

  function automatic byte unsigned rand_char();
    int r;
    byte unsigned ops[4];
    ops = '{8'd43, 8'd45, 8'd42, 8'd47};
    r = $urandom_range(0, 99);
    if (r < 40)      return 8'(48 + $urandom_range(0, 9));
    else if (r < 65) return ops[$urandom_range(0, 3)];
    else if (r < 80) return 8'd40;
    else if (r < 95) return 8'd41;
    else             return 8'($urandom_range(58, 127));
  endfunction

  // Monitor: one expectation per driven cycle, compared just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out", out, e.o);
        chk("err", err, e.e);
        chk("depth", depth, e.d);
        chk("cnt", cnt, e.c);
      end
    end
  end

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_s     = 8'd0;
    do_reset();
    step(1'b0, 8'd49);
    send("1+2*3");
    do_reset();
    send("(1+2)*3");
    do_reset();
    send("((((1))))");
    do_reset();
    send("(((((");
    do_reset();
    send("1+)2");
    do_reset();
    send("7");
    do_reset();
    send("12+3");
    do_reset();
    send("1");
    for (int i = 0; i < 3; i++) step(1'b0, 8'd43);
    do_reset();
    send("1a");
    do_reset();
    send("))");
    do_reset();
    send("()");
    do_reset();
    send("1(");
    do_reset();
    send("(1)2");
    do_reset();
    send("1-(2/3)");
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, rand_char());
    for (int r = 0; r < 60; r++) begin
      do_reset();
      for (int i = 0; i < $urandom_range(1, 25); i++) begin
        step(($urandom_range(0, 3) != 0), rand_char());
      end
    end
    repeat (3) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
